// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment patterns {a..g} active-low, BCD codes and digit types
package seg7_pkg;
  typedef logic [6:0] seg7_pat_t;
  typedef logic [3:0] bcd_digit_t;
  localparam seg7_pat_t SEG7_PAT_0 = 7'b0000001;
  localparam seg7_pat_t SEG7_PAT_1 = 7'b1001111;
  localparam seg7_pat_t SEG7_PAT_2 = 7'b0010010;
  localparam seg7_pat_t SEG7_PAT_3 = 7'b0000110;
  localparam seg7_pat_t SEG7_PAT_4 = 7'b1001100;
  localparam seg7_pat_t SEG7_PAT_5 = 7'b0100100;
  localparam seg7_pat_t SEG7_PAT_6 = 7'b0100000;
  localparam seg7_pat_t SEG7_PAT_7 = 7'b0001111;
  localparam seg7_pat_t SEG7_PAT_8 = 7'b0000000;
  localparam seg7_pat_t SEG7_PAT_9 = 7'b0000100;
  localparam seg7_pat_t SEG7_PAT_BLANK = 7'b1111111;
  localparam bcd_digit_t BCD_BLANK = 4'hF;
  localparam bcd_digit_t BCD_ILLEGAL = 4'hE;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational exact-match decode; in seg (7), out bcd (4: 0-9, F blank, E illegal), err (1)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg7_pat_t  seg,
  output bcd_digit_t bcd,
  output logic       err
);
  always_comb begin
    bcd = BCD_ILLEGAL;
    case (seg)
      SEG7_PAT_0: bcd = 4'd0;
      SEG7_PAT_1: bcd = 4'd1;
      SEG7_PAT_2: bcd = 4'd2;
      SEG7_PAT_3: bcd = 4'd3;
      SEG7_PAT_4: bcd = 4'd4;
      SEG7_PAT_5: bcd = 4'd5;
      SEG7_PAT_6: bcd = 4'd6;
      SEG7_PAT_7: bcd = 4'd7;
      SEG7_PAT_8: bcd = 4'd8;
      SEG7_PAT_9: bcd = 4'd9;
      SEG7_PAT_BLANK: bcd = BCD_BLANK;
      default: ;
    endcase
    err = bcd == BCD_ILLEGAL;
  end
endmodule

// File: rtl/seg7_scan_to_bcd.sv
// seg7_scan_to_bcd: rebuild stable BCD frames from a scanned 7-seg bus; in clk, rst, seg[7], dig_en[N], out_ready; out out_valid, bcd[4N], digit_err[N], overrun; SEG7_SCAN_DP_EN adds dp in, dp_out[N] out
module seg7_scan_to_bcd
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_SCANS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  seg7_pat_t               seg,
  input  logic [NUM_DIGITS-1:0]   dig_en,
`ifdef SEG7_SCAN_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    overrun
);
`ifdef SEG7_SCAN_DP_EN
  localparam int W = 6;
`else
  localparam int W = 5;
`endif
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] S = 4'(STABLE_SCANS);
  seg7_pat_t seg_r;
  logic [NUM_DIGITS-1:0] dig_r, captured;
  logic [NUM_DIGITS-1:0][W-1:0] shadow, prev, last_pub;
  logic [W-1:0] slot_new;
  logic [IW-1:0] idx;
  logic [3:0] cnt, cnt_nx;
  bcd_digit_t dec_bcd;
  logic dec_err, cap, complete, eq, publish;
  seg7_pattern_decode u_dec (.seg(seg_r), .bcd(dec_bcd), .err(dec_err));
`ifdef SEG7_SCAN_DP_EN
  logic dp_r;
  assign slot_new = {~dp_r, dec_err, dec_bcd};
`else
  assign slot_new = {dec_err, dec_bcd};
`endif
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (dig_r[i]) idx = IW'(i);
  end
  // dig_r holds the strobe of the previous cycle, so a change on dig_en marks the last cycle of its window
  assign cap = $onehot(dig_r) && dig_en != dig_r;
  assign complete = &captured;
  assign eq = shadow == prev;
  assign cnt_nx = !eq ? 4'd1 : cnt == S ? S : cnt + 4'd1;
  // a saturated counter on an equal frame is not a fresh arrival at the threshold
  assign publish = complete && cnt_nx == S && (!eq || cnt != S) && shadow != last_pub;
  always_comb begin
    bcd = '0;
    digit_err = '0;
`ifdef SEG7_SCAN_DP_EN
    dp_out = '0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd[4*i +: 4] = last_pub[i][3:0];
      digit_err[i] = last_pub[i][4];
`ifdef SEG7_SCAN_DP_EN
      dp_out[i] = last_pub[i][5];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= SEG7_PAT_BLANK;
      dig_r <= '0;
`ifdef SEG7_SCAN_DP_EN
      dp_r <= 1'b1;
`endif
      captured <= '0;
      shadow <= '0;
      prev <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) last_pub[i] <= W'(BCD_BLANK);
    end else begin
      seg_r <= seg;
      dig_r <= dig_en;
`ifdef SEG7_SCAN_DP_EN
      dp_r <= dp;
`endif
      if (cap) shadow[idx] <= slot_new;
      captured <= (complete ? '0 : captured) | (cap ? dig_r : '0);
      if (complete) cnt <= cnt_nx;
      if (complete && !eq) prev <= shadow;
      // last_pub doubles as the output holding register
      if (publish && (!out_valid || out_ready)) begin
        last_pub <= shadow;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      if (publish && out_valid && !out_ready) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// tb_seg7_scan_to_bcd: scoreboard bench for seg7_scan_to_bcd with directed scan vectors
module tb_seg7_scan_to_bcd;
  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
    logic [3:0]  dp;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic out_ready, out_valid, overrun;
  logic [15:0] bcd;
  logic [3:0] digit_err;
`ifdef SEG7_SCAN_DP_EN
  logic dp;
  logic [3:0] dp_out;
`endif
  exp_t q[$];
  int passed = 0, total = 0, n_acc = 0;
  seg7_scan_to_bcd #(.NUM_DIGITS(4), .STABLE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
`ifdef SEG7_SCAN_DP_EN
    .dp(dp), .dp_out(dp_out),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .bcd(bcd),
    .digit_err(digit_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_acc++;
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_publish: got bcd %h err %b want no publish", bcd, digit_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pub_bcd", 32'(bcd), 32'(e.bcd));
        check("pub_err", 32'(digit_err), 32'(e.err));
`ifdef SEG7_SCAN_DP_EN
        check("pub_dp", 32'(dp_out), 32'(e.dp));
`endif
      end
    end
  end
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction
  function automatic logic [27:0] pats_of(input logic [15:0] v);
    logic [27:0] p;
    for (int d = 0; d < 4; d++) p[7*d +: 7] = enc(v[4*d +: 4]);
    return p;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    dig_en = 4'b0;
    seg = 7'h7f;
    repeat (n) tick();
  endtask
  task automatic scan(input logic [27:0] pats, input logic [3:0] dpm, input int frames, input bit glitch);
    for (int f = 0; f < frames; f++)
      for (int d = 0; d < 4; d++) begin
        dig_en = 4'b1 << d;
        seg = pats[7*d +: 7];
`ifdef SEG7_SCAN_DP_EN
        dp = ~dpm[d];
`endif
        tick();
        tick();
        if (glitch) begin
          dig_en = 4'b0110;
          seg = 7'h7f;
          tick();
        end
      end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'h0000FFFF);
    check({tag, "_err"}, 32'(digit_err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [27:0] p;
    rst = 1'b1;
    dig_en = 4'b0;
    seg = 7'h7f;
    out_ready = 1'b1;
`ifdef SEG7_SCAN_DP_EN
    dp = 1'b1;
`endif
    repeat (3) tick();
    check_reset("rst0");
    rst = 1'b0;
    tick();
    q.push_back(exp_t'{16'h1234, 4'b0000, 4'b0000});
    scan(pats_of(16'h1234), 4'b0, 3, 1'b0);
    idle(4);
    drain();
    check("t1_one_pulse", 32'(n_acc), 32'd1);
    scan(pats_of(16'h1234), 4'b0, 3, 1'b0);
    idle(4);
    check("t1_no_repub", 32'(n_acc), 32'd1);
    p = pats_of(16'h1234);
    p[14 +: 7] = 7'b1111110;
    q.push_back(exp_t'{16'h1E34, 4'b0100, 4'b0000});
    scan(p, 4'b0, 3, 1'b0);
    idle(4);
    drain();
    q.push_back(exp_t'{16'hFFFF, 4'b0000, 4'b0000});
    scan(28'hFFFFFFF, 4'b0, 3, 1'b0);
    idle(4);
    drain();
    out_ready = 1'b0;
    q.push_back(exp_t'{16'h0042, 4'b0000, 4'b0000});
    scan(pats_of(16'h0042), 4'b0, 3, 1'b0);
    idle(4);
    check("t3_valid_held", 32'(out_valid), 32'd1);
    check("t3_no_overrun_yet", 32'(overrun), 32'd0);
    scan(pats_of(16'h0099), 4'b0, 3, 1'b0);
    idle(4);
    check("t3_bcd_held", 32'(bcd), 32'h00000042);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_valid_still", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("t3_valid_drop", 32'(out_valid), 32'd0);
    check("t3_acc", 32'(n_acc), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      scan(pats_of(16'h5555), 4'b0, 1, 1'b1);
      scan(pats_of(16'h5556), 4'b0, 1, 1'b1);
    end
    idle(4);
    check("t4_no_publish", 32'(n_acc), 32'd4);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);
    scan(pats_of(16'h7777), 4'b0, 2, 1'b0);
    seg = enc(4'd7);
    dig_en = 4'b0001;
    tick();
    tick();
    dig_en = 4'b0010;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check_reset("t5_rst");
    dig_en = 4'b0;
    tick();
    rst = 1'b0;
    tick();
    scan(pats_of(16'h7777), 4'b0, 2, 1'b0);
    idle(4);
    check("t5_not_yet", 32'(n_acc), 32'd4);
    q.push_back(exp_t'{16'h7777, 4'b0000, 4'b0000});
    scan(pats_of(16'h7777), 4'b0, 1, 1'b0);
    idle(4);
    drain();
    check("t5_acc", 32'(n_acc), 32'd5);
`ifdef SEG7_SCAN_DP_EN
    q.push_back(exp_t'{16'h1234, 4'b0000, 4'b0010});
    scan(pats_of(16'h1234), 4'b0010, 3, 1'b0);
    idle(4);
    drain();
    q.push_back(exp_t'{16'h1234, 4'b0000, 4'b0001});
    scan(pats_of(16'h1234), 4'b0001, 3, 1'b0);
    idle(4);
    drain();
    check("t6_acc", 32'(n_acc), 32'd7);
`endif
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
